// File: rtl/tick_divider_bank.sv
// NUM_CH independent programmable clock dividers with boundary-safe divisor reload and global phase restart.
// Optional readback ports (div_rdata, div_pend) are built when TICK_DIV_READBACK_EN is defined.
module tick_divider_bank #(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 26,
    parameter int CH_IDX_W    = 3
) (
    input  logic                clk_25MHz,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_restart,
    input  logic                div_wr,
    input  logic [CH_IDX_W-1:0] div_ch,
    input  logic [CNT_W-1:0]    div_val,
    output logic [NUM_CH-1:0]   clk_out,
    output logic [NUM_CH-1:0]   tick
`ifdef TICK_DIV_READBACK_EN
    ,
    output logic [CNT_W-1:0]    div_rdata,
    output logic [NUM_CH-1:0]   div_pend
`endif
);

    // Channel i defaults to max(2, CLK_FREQ_HZ / 10**i): 1 Hz, 10 Hz, 100 Hz, ...
    function automatic logic [CNT_W-1:0] reset_div(input int idx);
        longint q;
        q = longint'(CLK_FREQ_HZ);
        for (int k = 0; k < idx; k++) begin
            q = q / 10;
        end
        if (q < 2) begin
            q = 2;
        end
        return CNT_W'(q);
    endfunction

    logic [CNT_W-1:0] w_div_clamped;

    assign w_div_clamped = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;

`ifdef TICK_DIV_READBACK_EN
    logic [CNT_W-1:0] w_div_act [NUM_CH];

    always_comb begin
        div_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (32'(div_ch) == i) begin
                div_rdata = w_div_act[i];
            end
        end
    end
`else
    // No readback path in this build; channel logic below is unchanged.
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            localparam logic [CNT_W-1:0] RST_DIV = reset_div(gi);

            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_div_act;
            logic [CNT_W-1:0] r_div_shd;
            logic             r_pend;
            logic             r_clk_out;
            logic             r_tick;

            logic             w_wr_hit;
            logic             w_wrap;
            logic [CNT_W-1:0] w_cnt_inc;
            logic [CNT_W-1:0] w_half;

            // Out-of-range indices never match any generated channel, so such writes vanish.
            assign w_wr_hit  = div_wr && (32'(div_ch) == gi);
            assign w_wrap    = (r_cnt == (r_div_act - CNT_W'(1)));
            assign w_cnt_inc = r_cnt + CNT_W'(1);
            assign w_half    = (r_div_act >> 1) + {{(CNT_W-1){1'b0}}, r_div_act[0]};

            always_ff @(posedge clk_25MHz) begin
                if (!rst_n) begin
                    r_cnt     <= '0;
                    r_div_act <= RST_DIV;
                    r_div_shd <= RST_DIV;
                    r_pend    <= 1'b0;
                    r_clk_out <= 1'b0;
                    r_tick    <= 1'b0;
                end else if (sync_restart || !ch_en[gi]) begin
                    // Held at phase 0: no period is running, so divisors may change at once.
                    r_cnt     <= '0;
                    r_clk_out <= 1'b0;
                    r_tick    <= 1'b0;
                    r_pend    <= 1'b0;
                    if (w_wr_hit) begin
                        r_div_act <= w_div_clamped;
                        r_div_shd <= w_div_clamped;
                    end else if (r_pend) begin
                        r_div_act <= r_div_shd;
                    end
                end else if (w_wrap) begin
                    r_cnt     <= '0;
                    r_clk_out <= 1'b1;
                    r_tick    <= 1'b1;
                    if (r_pend) begin
                        r_div_act <= r_div_shd;
                    end
                    // A write landing on the wrap edge waits for the following wrap.
                    r_pend <= w_wr_hit;
                    if (w_wr_hit) begin
                        r_div_shd <= w_div_clamped;
                    end
                end else begin
                    r_cnt     <= w_cnt_inc;
                    r_clk_out <= (w_cnt_inc < w_half);
                    r_tick    <= 1'b0;
                    if (w_wr_hit) begin
                        r_div_shd <= w_div_clamped;
                        r_pend    <= 1'b1;
                    end
                end
            end

            assign clk_out[gi] = r_clk_out;
            assign tick[gi]    = r_tick;

`ifdef TICK_DIV_READBACK_EN
            assign w_div_act[gi] = r_div_act;
            assign div_pend[gi]  = r_pend;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_tick_divider_bank.sv
// Bench for tick_divider_bank: vector table, directed corner sequences and a random run against a period-level model.
// Readback checks are compiled in when TICK_DIV_READBACK_EN is defined.
module tb_tick_divider_bank;

    localparam int NCH = 4;
    localparam int CW  = 26;
    localparam int IW  = 3;
    localparam int RST_D [NCH] = '{1000, 100, 10, 2};

    logic            clk_25MHz = 1'b0;
    logic            rst_n;
    logic [NCH-1:0]  ch_en;
    logic            sync_restart;
    logic            div_wr;
    logic [IW-1:0]   div_ch;
    logic [CW-1:0]   div_val;
    logic [NCH-1:0]  clk_out;
    logic [NCH-1:0]  tick;
`ifdef TICK_DIV_READBACK_EN
    logic [CW-1:0]   div_rdata;
    logic [NCH-1:0]  div_pend;
`endif

    tick_divider_bank #(
        .CLK_FREQ_HZ (1000),
        .NUM_CH      (NCH),
        .CNT_W       (CW),
        .CH_IDX_W    (IW)
    ) dut (
        .clk_25MHz    (clk_25MHz),
        .rst_n        (rst_n),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .div_wr       (div_wr),
        .div_ch       (div_ch),
        .div_val      (div_val),
        .clk_out      (clk_out),
        .tick         (tick)
`ifdef TICK_DIV_READBACK_EN
        ,
        .div_rdata    (div_rdata),
        .div_pend     (div_pend)
`endif
    );

    always #5 clk_25MHz = ~clk_25MHz;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) begin
                $display("FAIL %s: got %0d, expected %0d", name, act, exp);
            end
        end
    endtask

    // Model: each channel tracks edges elapsed in its current period; a period ends after exactly D edges.
    int m_el   [NCH];
    int m_d    [NCH];
    int m_shd  [NCH];
    bit m_pend [NCH];
    bit m_run  [NCH];
    bit m_tick [NCH];

    always @(posedge clk_25MHz) begin
        for (int i = 0; i < NCH; i++) begin
            bit wr;
            int v;
            wr = div_wr && (int'(div_ch) == i);
            v  = (div_val < 2) ? 2 : int'(div_val);
            if (!rst_n) begin
                m_d[i] = RST_D[i]; m_shd[i] = RST_D[i]; m_pend[i] = 0;
                m_el[i] = 0; m_run[i] = 0; m_tick[i] = 0;
            end else if (sync_restart || !ch_en[i]) begin
                if (wr) m_d[i] = v;
                else if (m_pend[i]) m_d[i] = m_shd[i];
                m_pend[i] = 0; m_el[i] = 0; m_run[i] = 0; m_tick[i] = 0;
            end else begin
                m_run[i] = 1;
                m_el[i]  = m_el[i] + 1;
                if (m_el[i] == m_d[i]) begin
                    m_el[i] = 0; m_tick[i] = 1;
                    if (m_pend[i]) m_d[i] = m_shd[i];
                    m_pend[i] = 0;
                end else begin
                    m_tick[i] = 0;
                end
                if (wr) begin
                    m_shd[i] = v; m_pend[i] = 1;
                end
            end
        end
    end

    always @(negedge clk_25MHz) begin
        logic [NCH-1:0] ec, et, ep;
        for (int i = 0; i < NCH; i++) begin
            ec[i] = m_run[i] && (m_el[i] < (m_d[i] + 1) / 2);
            et[i] = m_tick[i];
            ep[i] = m_pend[i];
        end
        check("model clk_out", 64'(clk_out), 64'(ec));
        check("model tick", 64'(tick), 64'(et));
`ifdef TICK_DIV_READBACK_EN
        check("model div_pend", 64'(div_pend), 64'(ep));
`else
        if (ep == '1 && NCH == 0) $display("unreachable");
`endif
    end

    task automatic wait_tick(input int ch, output int n);
        n = 0;
        do begin
            @(negedge clk_25MHz);
            n++;
        end while (tick[ch] !== 1'b1 && n < 3000);
    endtask

    task automatic period_from_tick(input int ch, output int per, output int hi);
        per = 0;
        hi  = 0;
        do begin
            if (clk_out[ch] === 1'b1) hi++;
            per++;
            @(negedge clk_25MHz);
        end while (tick[ch] !== 1'b1 && per < 3000);
    endtask

    typedef struct {
        int ch;
        int wr_val;
        int exp_per;
        int exp_hi;
        int exp_lo;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n2, per, hi;

        tbl[0] = '{1, 7, 7, 4, 3};
        tbl[1] = '{2, 2, 2, 1, 1};
        tbl[2] = '{0, 0, 2, 1, 1};
        tbl[3] = '{3, 1, 2, 1, 1};
        tbl[4] = '{0, 10, 10, 5, 5};
        tbl[5] = '{2, 5, 5, 3, 2};
        tbl[6] = '{1, 3, 3, 2, 1};

        rst_n = 1'b0; ch_en = '1; sync_restart = 1'b0;
        div_wr = 1'b0; div_ch = '0; div_val = '0;
        repeat (3) @(negedge clk_25MHz);
        check("reset clk_out", 64'(clk_out), 64'(0));
        check("reset tick", 64'(tick), 64'(0));
        rst_n = 1'b1;

        wait_tick(2, n);
        check("ch2 first tick edges", n, 10);
        period_from_tick(2, per, hi);
        check("ch2 default period", per, 10);
        check("ch2 default high", hi, 5);
        $display("reset defaults: ch2 first=%0d period=%0d high=%0d", n, per, hi);
        wait_tick(3, n);
        period_from_tick(3, per, hi);
        check("ch3 clamped period", per, 2);
        wait_tick(1, n);
        period_from_tick(1, per, hi);
        check("ch1 default period", per, 100);
        check("ch1 default high", hi, 50);
        wait_tick(0, n);
        period_from_tick(0, per, hi);
        check("ch0 default period", per, 1000);
        check("ch0 default high", hi, 500);
        $display("reset defaults: ch0 period=%0d high=%0d", per, hi);

        for (int v = 0; v < 7; v++) begin
            @(negedge clk_25MHz);
            ch_en[tbl[v].ch] = 1'b0;
            @(negedge clk_25MHz);
            div_wr = 1'b1; div_ch = IW'(tbl[v].ch); div_val = CW'(tbl[v].wr_val);
            @(negedge clk_25MHz);
            div_wr = 1'b0;
            ch_en[tbl[v].ch] = 1'b1;
            wait_tick(tbl[v].ch, n);
            period_from_tick(tbl[v].ch, per, hi);
            check($sformatf("vec%0d first tick", v), n, tbl[v].exp_per);
            check($sformatf("vec%0d period", v), per, tbl[v].exp_per);
            check($sformatf("vec%0d high", v), hi, tbl[v].exp_hi);
            check($sformatf("vec%0d low", v), per - hi, tbl[v].exp_lo);
            $display("vec %0d: ch%0d wrote %0d first=%0d period=%0d high=%0d",
                     v, tbl[v].ch, tbl[v].wr_val, n, per, hi);
        end

        // Boundary reload: ch0 at D=10, write D=4 while cnt=3.
        wait_tick(0, n);
        repeat (3) @(negedge clk_25MHz);
        div_wr = 1'b1; div_ch = 3'd0; div_val = CW'(4);
        @(negedge clk_25MHz);
        div_wr = 1'b0;
`ifdef TICK_DIV_READBACK_EN
        check("reload pend set", 64'(div_pend[0]), 64'(1));
`endif
        wait_tick(0, n);
        check("reload old period remainder", n, 6);
`ifdef TICK_DIV_READBACK_EN
        check("reload pend cleared", 64'(div_pend[0]), 64'(0));
`endif
        period_from_tick(0, per, hi);
        check("reload new period", per, 4);
        check("reload new high", hi, 2);
        $display("boundary reload: remainder=%0d new period=%0d", n, per);

        // Out-of-range channel index must leave every channel untouched.
        @(negedge clk_25MHz);
        div_wr = 1'b1; div_ch = 3'd5; div_val = CW'(9);
`ifdef TICK_DIV_READBACK_EN
        #1 check("readback out of range", 64'(div_rdata), 64'(0));
`endif
        @(negedge clk_25MHz);
        div_wr = 1'b0; div_ch = 3'd1;
`ifdef TICK_DIV_READBACK_EN
        #1 check("readback ch1", 64'(div_rdata), 64'(3));
`endif
        wait_tick(1, n);
        period_from_tick(1, per, hi);
        check("ignore ch1 period", per, 3);
        $display("ignored write ch5: ch1 period=%0d", per);

        // sync_restart with a pending shadow on ch2.
        @(negedge clk_25MHz);
        div_wr = 1'b1; div_ch = 3'd2; div_val = CW'(8);
        @(negedge clk_25MHz);
        div_wr = 1'b0; sync_restart = 1'b1;
        @(negedge clk_25MHz);
        sync_restart = 1'b0;
        check("restart clk_out", 64'(clk_out), 64'(0));
        check("restart tick", 64'(tick), 64'(0));
`ifdef TICK_DIV_READBACK_EN
        check("restart pend", 64'(div_pend), 64'(0));
        div_ch = 3'd2;
        #1 check("restart commit readback", 64'(div_rdata), 64'(8));
`endif
        wait_tick(0, n);
        check("restart ch0 tick", n, 4);
        wait_tick(2, n2);
        check("restart ch2 tick", n + n2, 8);
        $display("sync restart: ch0 tick after %0d, ch2 tick after %0d", n, n + n2);

        // Reset during an active tick.
        wait_tick(3, n);
        rst_n = 1'b0;
        @(negedge clk_25MHz);
        check("midreset tick", 64'(tick), 64'(0));
        check("midreset clk_out", 64'(clk_out), 64'(0));
        rst_n = 1'b1;
        wait_tick(2, n);
        check("midreset ch2 first tick", n, 10);
`ifdef TICK_DIV_READBACK_EN
        div_ch = 3'd0;
        #1 check("midreset ch0 divisor", 64'(div_rdata), 64'(1000));
`endif
        period_from_tick(2, per, hi);
        check("midreset ch2 period", per, 10);
        $display("mid reset: ch2 first=%0d period=%0d", n, per);

        for (int c = 0; c < 2000; c++) begin
            @(negedge clk_25MHz);
            for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 19) != 0);
            div_wr       = ($urandom_range(0, 7) == 0);
            div_ch       = IW'($urandom_range(0, 7));
            div_val      = CW'($urandom_range(0, 12));
            sync_restart = ($urandom_range(0, 49) == 0);
            rst_n        = ($urandom_range(0, 299) != 0);
        end
        @(negedge clk_25MHz);
        rst_n = 1'b1; div_wr = 1'b0; sync_restart = 1'b0; ch_en = '1;
        repeat (5) @(negedge clk_25MHz);
        $display("random run: 2000 cycles checked against model");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
